// File: rtl/flash_fetch.sv
// flash_fetch: flash-region instruction fetch with a word prefetch FIFO
// feeding 16-bit Thumb halfwords to the decoder over valid/ready.
module flash_fetch #(
    parameter int                ADDR_W   = 10,
    parameter logic [ADDR_W+1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ld_flash,
    output logic [ADDR_W-1:0] flash_addr_PC,
    input  logic              flash_busy,
    input  logic [31:0]       dout_flash,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [15:0]       instr,
    output logic [ADDR_W+1:0] instr_pc,
    input  logic              branch_valid,
    input  logic [ADDR_W+1:0] branch_target
);

    localparam int          PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_BUSY, WAIT_DATA} state_t;

    state_t            state;
    logic [ADDR_W-1:0] fetch_ptr;
    logic [ADDR_W-1:0] next_ptr;
    logic [ADDR_W-1:0] tgt_word;
    logic [31:0]       fifo_data [DEPTH];
    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;
    logic [PW:0]       count_nx;
    logic              half_sel;
    logic              discard;
    logic              hs;
    logic              pop;
    logic              push;
    logic              unused_bit;

    assign tgt_word    = branch_target[ADDR_W+1:2];
    assign unused_bit  = branch_target[0];
    assign next_ptr    = fetch_ptr + ADDR_W'(1);
    assign instr_valid = count != '0;
    assign hs          = instr_valid && instr_ready;
    assign pop         = hs && half_sel && !branch_valid;
    assign push        = state == WAIT_DATA && !flash_busy
                         && !discard && !branch_valid;
    assign count_nx    = count + (PW+1)'(push) - (PW+1)'(pop);

    always_comb begin
        instr    = '0;
        instr_pc = {fetch_ptr, half_sel, 1'b0};
        if (instr_valid) begin
            instr    = half_sel ? fifo_data[rd_ptr][31:16]
                                : fifo_data[rd_ptr][15:0];
            instr_pc = {fifo_addr[rd_ptr], half_sel, 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= dout_flash;
            fifo_addr[wr_ptr] <= fetch_ptr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            ld_flash      <= 1'b0;
            flash_addr_PC <= RESET_PC[ADDR_W+1:2];
            fetch_ptr     <= RESET_PC[ADDR_W+1:2];
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            half_sel      <= RESET_PC[1];
            discard       <= 1'b0;
        end else if (branch_valid) begin
            // in-flight reads finish on the flash side but are dropped
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fetch_ptr <= tgt_word;
            half_sel  <= branch_target[1];
            ld_flash  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!flash_busy) begin
                        state         <= REQ;
                        ld_flash      <= 1'b1;
                        flash_addr_PC <= tgt_word;
                    end
                end
                REQ: begin
                    state   <= WAIT_BUSY;
                    discard <= 1'b1;
                end
                WAIT_BUSY: discard <= 1'b1;
                WAIT_DATA: begin
                    if (flash_busy) begin
                        discard <= 1'b1;
                    end else begin
                        state         <= REQ;
                        ld_flash      <= 1'b1;
                        flash_addr_PC <= tgt_word;
                        discard       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end else begin
            ld_flash <= 1'b0;
            count    <= count_nx;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (hs) half_sel <= ~half_sel;
            unique case (state)
                IDLE: begin
                    if (count < FULL && !flash_busy) begin
                        state         <= REQ;
                        ld_flash      <= 1'b1;
                        flash_addr_PC <= fetch_ptr;
                    end
                end
                REQ: state <= WAIT_BUSY;
                WAIT_BUSY: begin
                    if (flash_busy) state <= WAIT_DATA;
                end
                WAIT_DATA: begin
                    if (!flash_busy) begin
                        discard <= 1'b0;
                        if (!discard) fetch_ptr <= next_ptr;
                        if (count_nx < FULL) begin
                            state         <= REQ;
                            ld_flash      <= 1'b1;
                            flash_addr_PC <= discard ? fetch_ptr : next_ptr;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_fetch.sv
// tb_flash_fetch: directed bench with a flash responder model and a
// halfword scoreboard for flash_fetch.
module tb_flash_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_flash;
    logic [9:0]  flash_addr_PC;
    logic        flash_busy = 1'b0;
    logic [31:0] dout_flash = 32'hDEADBEEF;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [11:0] instr_pc;
    logic        branch_valid;
    logic [11:0] branch_target;

    int checks   = 0;
    int failures = 0;
    int popped   = 0;
    int busy_len = 1;

    logic [31:0] mem [1024];
    logic [27:0] exp_q [$];
    logic [9:0]  req_log [$];

    flash_fetch #(.ADDR_W(10), .RESET_PC(12'h000), .DEPTH(2)) dut (
        .clk(clk),
        .rst(rst),
        .ld_flash(ld_flash),
        .flash_addr_PC(flash_addr_PC),
        .flash_busy(flash_busy),
        .dout_flash(dout_flash),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr(instr),
        .instr_pc(instr_pc),
        .branch_valid(branch_valid),
        .branch_target(branch_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_stream(input logic [11:0] ba, input int n);
        logic [9:0] w;
        logic       h;
        w = ba[11:2];
        h = ba[1];
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({w, h, 1'b0,
                             h ? mem[w][31:16] : mem[w][15:0]});
            if (h) w = w + 10'd1;
            h = ~h;
        end
    endtask

    task automatic wait_pops(input int target, input int budget,
                             input string tag);
        for (int i = 0; i < budget && popped < target; i++) step();
        chk(tag, 32'(popped >= target), 1);
    endtask

    // flash responder: busy from the cycle after ld_flash for busy_len cycles
    initial begin : responder
        logic       new_ld;
        int         left;
        logic [9:0] paddr;
        new_ld = 1'b0;
        left   = 0;
        paddr  = '0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (ld_flash) begin
                    chk("ld_while_busy", flash_busy, 0);
                    new_ld = 1'b1;
                    paddr  = flash_addr_PC;
                    req_log.push_back(flash_addr_PC);
                end else if (flash_busy) begin
                    chk("addr_stable", flash_addr_PC, paddr);
                end
            end
            @(posedge clk);
            #1;
            if (rst !== 1'b1) begin
                flash_busy = 1'b0;
                new_ld     = 1'b0;
                left       = 0;
                dout_flash = 32'hDEADBEEF;
            end else if (new_ld) begin
                new_ld     = 1'b0;
                flash_busy = 1'b1;
                left       = busy_len - 1;
                dout_flash = 32'hDEADBEEF;
            end else if (flash_busy && left > 0) begin
                left--;
            end else if (flash_busy) begin
                flash_busy = 1'b0;
                dout_flash = mem[paddr];
            end else begin
                dout_flash = 32'hDEADBEEF;
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1 && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", exp_q.size(), 1);
            end else begin
                logic [27:0] e;
                e = exp_q.pop_front();
                chk("sb_instr", instr, e[15:0]);
                chk("sb_pc", instr_pc, e[27:16]);
            end
            popped++;
        end
    end

    initial begin
        int p0;
        int ri;
        for (int i = 0; i < 1024; i++)
            mem[i] = ((32'h8000 + i) << 16) | (32'h4000 + i);
        mem[0] = 32'hBBBBAAAA;
        mem[1] = 32'hDDDDCCCC;

        rst           = 1'b0;
        instr_ready   = 1'b0;
        branch_valid  = 1'b0;
        branch_target = '0;
        repeat (3) step();
        chk("rst_ld", ld_flash, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_addr", flash_addr_PC, 0);
        chk("rst_pc", instr_pc, 0);

        // streaming from reset
        rst         = 1'b1;
        instr_ready = 1'b1;
        push_stream(12'h000, 64);
        wait_pops(4, 100, "A_pops");
        chk("A_nreq", 32'(req_log.size() >= 3), 1);
        if (req_log.size() >= 3) begin
            chk("A_req0", req_log[0], 0);
            chk("A_req1", req_log[1], 1);
            chk("A_req2", req_log[2], 2);
        end

        // decoder stalled: FIFO fills, output held
        rst         = 1'b0;
        instr_ready = 1'b0;
        step();
        step();
        exp_q.delete();
        req_log.delete();
        rst = 1'b1;
        repeat (10) step();
        chk("B_hold_mid", instr, 16'hAAAA);
        repeat (10) step();
        chk("B_nreq", req_log.size(), 2);
        chk("B_valid", instr_valid, 1);
        chk("B_instr", instr, 16'hAAAA);
        chk("B_pc", instr_pc, 0);

        busy_len = 3;
        push_stream(12'h000, 40);
        p0          = popped;
        instr_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (req_log.size() >= 3 && flash_busy) break;
        end
        chk("B_third", 32'(req_log.size() >= 3 && flash_busy), 1);
        chk("B_pop_first", 32'(popped - p0 >= 2), 1);
        if (req_log.size() >= 3) chk("B_req2", req_log[2], 2);

        // branch while word 2 is in flight
        step();
        instr_ready   = 1'b0;
        branch_valid  = 1'b1;
        branch_target = 12'h016;
        step();
        branch_valid = 1'b0;
        chk("C_valid_br", instr_valid, 0);
        ri = req_log.size();
        exp_q.delete();
        push_stream(12'h016, 40);
        p0          = popped;
        instr_ready = 1'b1;
        wait_pops(p0 + 5, 200, "C_pops");
        chk("C_nreq", 32'(req_log.size() > ri), 1);
        if (req_log.size() > ri) chk("C_req5", req_log[ri], 5);

        // slow flash
        busy_len = 7;
        wait_pops(popped + 6, 400, "D_pops");

        // wrap at the top of the flash
        instr_ready   = 1'b0;
        branch_valid  = 1'b1;
        branch_target = 12'hFFC;
        step();
        branch_valid = 1'b0;
        ri = req_log.size();
        exp_q.delete();
        push_stream(12'hFFC, 40);
        busy_len    = 1;
        instr_ready = 1'b1;
        wait_pops(popped + 6, 300, "E_pops");
        chk("E_nreq", 32'(req_log.size() > ri + 1), 1);
        if (req_log.size() > ri + 1) begin
            chk("E_req_top", req_log[ri], 10'd1023);
            chk("E_req_wrap", req_log[ri+1], 0);
        end

        // asynchronous reset mid-read
        busy_len = 3;
        for (int i = 0; i < 60; i++) begin
            step();
            if (flash_busy) break;
        end
        chk("F_busy", flash_busy, 1);
        #1;
        rst = 1'b0;
        #1;
        chk("F_ld", ld_flash, 0);
        chk("F_valid", instr_valid, 0);
        chk("F_instr", instr, 0);
        chk("F_addr", flash_addr_PC, 0);
        chk("F_pc", instr_pc, 0);
        step();
        exp_q.delete();
        req_log.delete();
        step();
        busy_len = 1;
        push_stream(12'h000, 20);
        rst = 1'b1;
        wait_pops(popped + 4, 100, "F_pops");
        chk("F_nreq", 32'(req_log.size() >= 1), 1);
        if (req_log.size() >= 1) chk("F_req0", req_log[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
